// File: rtl/icap_readback.sv
// ICAPE2 configuration readback engine: issues the FAR/FDRO command sequence,
// reads word_count words through a latency-tracked FIFO onto AXI-Stream, then desyncs.
module icap_readback #(
    parameter int ICAP_RD_LAT = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] frame_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_i,
    input  logic [31:0] icap_o
);
    localparam int          DATA_W  = 32;
    localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, CMD, TO_RD, READ, TO_WR, DESYNC, FLUSH} state_t;

    state_t                 state;
    logic [2:0]             idx;
    logic [31:0]            far_q;
    logic [15:0]            wc_q;
    logic [15:0]            issued;
    logic [15:0]            popped;
    logic [ICAP_RD_LAT-1:0] inflight;
    logic [AW:0]            fifo_cnt;
    logic [AW:0]            occ;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [DATA_W-1:0]      mem [FIFO_DEPTH];
    logic                   last_seen;
    logic                   accept;
    logic                   issue;
    logic                   read_now;
    logic                   push;
    logic                   pop;

    function automatic logic [31:0] cmd_word(input logic [2:0] i, input logic [31:0] far,
                                             input logic [15:0] wc);
        case (i)
            3'd0:    cmd_word = 32'hAA99_5566;
            3'd1:    cmd_word = 32'h2000_0000;
            3'd2:    cmd_word = 32'h3000_8001;
            3'd3:    cmd_word = 32'h0000_0004;
            3'd4:    cmd_word = 32'h3000_2001;
            3'd5:    cmd_word = far;
            3'd6:    cmd_word = 32'h2800_6000;
            default: cmd_word = {16'h4800, wc};
        endcase
    endfunction

    function automatic logic [31:0] desync_word(input logic [1:0] i);
        case (i)
            2'd0:    desync_word = 32'h3000_8001;
            2'd1:    desync_word = 32'h0000_000D;
            default: desync_word = 32'h2000_0000;
        endcase
    endfunction

    // occ counts FIFO words plus reads already committed, so a read is only issued
    // when its word is guaranteed a slot when it lands ICAP_RD_LAT cycles later.
    assign accept   = (state == IDLE) && start && (word_count != 16'd0);
    assign read_now = !icap_csib && icap_rdwrb;
    assign push     = inflight[ICAP_RD_LAT-1];
    assign pop      = m_axis_tvalid && m_axis_tready;
    assign issue    = ((state == TO_RD) || (state == READ)) && (occ < DEPTH_V) && (issued < wc_q);

    assign m_axis_tvalid = (fifo_cnt != '0);
    assign m_axis_tdata  = mem[rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid && (popped == wc_q - 16'd1);
    assign m_axis_tkeep  = 4'hF;

    always_ff @(posedge clk) begin
        if (accept) begin
            far_q <= frame_addr;
            wc_q  <= word_count;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= icap_o;
    end

    // ICAP return pipeline and FIFO bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight  <= '0;
            fifo_cnt  <= '0;
            occ       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            issued    <= '0;
            popped    <= '0;
            last_seen <= 1'b0;
        end else begin
            inflight[0] <= read_now;
            for (int k = 1; k < ICAP_RD_LAT; k++) inflight[k] <= inflight[k-1];
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
            occ      <= occ + (AW+1)'(issue) - (AW+1)'(pop);
            if (accept) begin
                issued    <= '0;
                popped    <= '0;
                last_seen <= 1'b0;
            end else begin
                if (issue) issued <= issued + 16'd1;
                if (pop) begin
                    popped <= popped + 16'd1;
                    if (m_axis_tlast) last_seen <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            icap_csib  <= 1'b1;
            icap_rdwrb <= 1'b0;
            icap_i     <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= CMD;
                        idx        <= '0;
                        busy       <= 1'b1;
                        icap_csib  <= 1'b0;
                        icap_rdwrb <= 1'b0;
                        icap_i     <= cmd_word(3'd0, frame_addr, word_count);
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                CMD: begin
                    if (idx == 3'd7) begin
                        // CSIB rises together with RDWRB so the direction flips while deselected
                        state      <= TO_RD;
                        icap_csib  <= 1'b1;
                        icap_rdwrb <= 1'b1;
                        icap_i     <= '0;
                    end else begin
                        idx    <= idx + 3'd1;
                        icap_i <= cmd_word(idx + 3'd1, far_q, wc_q);
                    end
                end
                TO_RD: begin
                    state     <= READ;
                    icap_csib <= !issue;
                end
                READ: begin
                    icap_csib <= !issue;
                    if ((issued == wc_q) && !read_now && (inflight == '0)) begin
                        state      <= TO_WR;
                        icap_csib  <= 1'b1;
                        icap_rdwrb <= 1'b0;
                    end
                end
                TO_WR: begin
                    state     <= DESYNC;
                    idx       <= '0;
                    icap_csib <= 1'b0;
                    icap_i    <= desync_word(2'd0);
                end
                DESYNC: begin
                    if (idx == 3'd3) begin
                        state     <= FLUSH;
                        icap_csib <= 1'b1;
                        icap_i    <= '0;
                    end else begin
                        idx    <= idx + 3'd1;
                        icap_i <= desync_word(idx[1:0] + 2'd1);
                    end
                end
                FLUSH: begin
                    if (last_seen && (fifo_cnt == '0)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icap_readback.sv
// Directed bench for icap_readback with a behavioural ICAPE2 read-latency model.
module tb_icap_readback;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] frame_addr;
    logic [15:0] word_count;
    logic        busy, done, err;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        icap_csib, icap_rdwrb;
    logic [31:0] icap_i, icap_o;

    icap_readback #(.ICAP_RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .start(start), .frame_addr(frame_addr),
        .word_count(word_count), .busy(busy), .done(done), .err(err),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i), .icap_o(icap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int unsigned k);
        return 32'h1234_5678 + k * 32'h0001_0003;
    endfunction

    function automatic logic [31:0] exp_wr(input int i, input logic [31:0] far, input logic [15:0] wc);
        case (i)
            0:       return 32'hAA99_5566;
            1:       return 32'h2000_0000;
            2:       return 32'h3000_8001;
            3:       return 32'h0000_0004;
            4:       return 32'h3000_2001;
            5:       return far;
            6:       return 32'h2800_6000;
            7:       return {16'h4800, wc};
            8:       return 32'h3000_8001;
            9:       return 32'h0000_000D;
            default: return 32'h2000_0000;
        endcase
    endfunction

    // ICAP model: a read sampled in cycle t presents its word on icap_o during cycle t+LAT
    int unsigned rd_idx = 0;
    logic        mp_v [LAT];
    logic [31:0] mp_d [LAT];
    always @(posedge clk) begin
        mp_v[0] <= !icap_csib && icap_rdwrb;
        mp_d[0] <= pat(rd_idx);
        if (!icap_csib && icap_rdwrb) rd_idx <= rd_idx + 1;
        for (int k = 1; k < LAT; k++) begin
            mp_v[k] <= mp_v[k-1];
            mp_d[k] <= mp_d[k-1];
        end
    end
    assign icap_o = mp_v[LAT-1] ? mp_d[LAT-1] : 32'hDEAD_BEEF;

    logic [31:0] wr_log[$];
    logic [31:0] beats[$];
    logic        lasts[$];
    int          rd_total = 0, done_cnt = 0, err_cnt = 0, busy_cyc = 0;
    int          proto_err = 0, stab_err = 0;
    logic        rdwrb_prev = 1'b0, stall_prev = 1'b0, last_prev = 1'b0;
    logic [31:0] data_prev = '0;

    always @(negedge clk) begin
        if (!resetn) begin
            stall_prev = 1'b0;
        end else begin
            if (!icap_csib && !icap_rdwrb) wr_log.push_back(icap_i);
            if (!icap_csib && icap_rdwrb) rd_total++;
            if ((icap_rdwrb != rdwrb_prev) && !icap_csib) proto_err++;
            if (stall_prev && !(m_axis_tvalid && m_axis_tdata == data_prev && m_axis_tlast == last_prev))
                stab_err++;
            if (m_axis_tvalid && m_axis_tready) begin
                beats.push_back(m_axis_tdata);
                lasts.push_back(m_axis_tlast);
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            data_prev  = m_axis_tdata;
            last_prev  = m_axis_tlast;
            if (done) done_cnt++;
            if (err)  err_cnt++;
            if (busy) busy_cyc++;
        end
        rdwrb_prev = icap_rdwrb;
    end

    bit rnd_mode = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) m_axis_tready = ($urandom_range(0, 3) != 0);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] far;
        logic [15:0] wc;
        int          stall;
        bit          rnd;
        bit          poke;
        bit          exp_err;
        int          exp_beats;
    } vec_t;

    task automatic run_txn(input vec_t v);
        int unsigned mb;
        int wb, bb, db, eb, rb, bc, bad, nlast, lastpos, wbad, bound;
        mb = rd_idx; wb = wr_log.size(); bb = beats.size();
        db = done_cnt; eb = err_cnt; rb = rd_total; bc = busy_cyc;
        @(negedge clk);
        start = 1'b1; frame_addr = v.far; word_count = v.wc;
        rnd_mode = v.rnd;
        if (!v.rnd) m_axis_tready = (v.stall == 0);
        @(negedge clk);
        start = 1'b0;
        if (v.exp_err) begin
            repeat (4) @(negedge clk);
            chk("zero_err_pulses", err_cnt - eb, 1);
            chk("zero_busy_cycles", busy_cyc - bc, 0);
            chk("zero_icap_writes", wr_log.size() - wb, 0);
            chk("zero_icap_reads", rd_total - rb, 0);
            return;
        end
        if (v.stall > 0) begin
            repeat (v.stall) @(negedge clk);
            chk("stall_reads_before_pop", rd_total - rb, DEPTH);
            m_axis_tready = 1'b1;
        end
        if (v.poke) begin
            for (int c = 0; c < 200 && (rd_total - rb) < 2; c++) @(negedge clk);
            start = 1'b1; word_count = 16'd3; frame_addr = 32'hFFFF_0000;
            @(negedge clk);
            start = 1'b0;
        end
        bound = v.exp_beats * 12 + 400;
        for (int c = 0; c < bound && done_cnt == db; c++) @(negedge clk);
        rnd_mode = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt - db, 1);
        chk("busy_after_done", busy, 0);
        chk("err_pulses", err_cnt - eb, 0);
        chk("beat_count", beats.size() - bb, v.exp_beats);
        bad = 0; nlast = 0; lastpos = -1;
        for (int j = 0; j < beats.size() - bb; j++) begin
            if (beats[bb+j] !== pat(mb + j)) bad++;
            if (lasts[bb+j]) begin nlast++; lastpos = j; end
        end
        chk("beat_data_bad", bad, 0);
        chk("tlast_count", nlast, 1);
        chk("tlast_pos", lastpos, v.exp_beats - 1);
        chk("icap_write_count", wr_log.size() - wb, 12);
        wbad = 0;
        for (int i = 0; i < 12 && (wb + i) < wr_log.size(); i++)
            if (wr_log[wb+i] !== exp_wr(i, v.far, v.wc)) wbad++;
        chk("icap_write_words_bad", wbad, 0);
        chk("icap_read_count", rd_total - rb, v.exp_beats);
    endtask

    vec_t tbl[6];

    initial begin
        int rb, db;
        tbl[0] = '{32'h0040_0000,   4,  0, 1'b0, 1'b0, 1'b0,   4};
        tbl[1] = '{32'h0000_1234,   1,  0, 1'b0, 1'b0, 1'b0,   1};
        tbl[2] = '{32'h0000_0000,   0,  0, 1'b0, 1'b0, 1'b1,   0};
        tbl[3] = '{32'h0080_0100,  20, 50, 1'b0, 1'b0, 1'b0,  20};
        tbl[4] = '{32'h0100_0000,  12,  0, 1'b0, 1'b1, 1'b0,  12};
        tbl[5] = '{32'h00C0_0000, 300,  0, 1'b1, 1'b0, 1'b0, 300};

        resetn = 1'b1; start = 1'b0; frame_addr = '0; word_count = '0; m_axis_tready = 1'b0;
        #1 resetn = 1'b0;
        #2;
        chk("rst_ctrl", {icap_csib, icap_rdwrb, busy, done, err, m_axis_tvalid, m_axis_tlast}, 7'b1000000);
        chk("rst_icap_i", icap_i, 32'h0);
        chk("rst_tkeep", m_axis_tkeep, 4'hF);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        @(negedge clk);
        start = 1'b1; word_count = 16'd0; frame_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        chk("err_next_cycle", err, 1);
        chk("err_busy_low", busy, 0);
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        chk("err_csib_idle", icap_csib, 1);

        for (int t = 0; t < 6; t++) run_txn(tbl[t]);

        rb = rd_total; db = done_cnt;
        @(negedge clk);
        start = 1'b1; frame_addr = 32'h0000_0800; word_count = 16'd20; m_axis_tready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && (rd_total - rb) < 7; c++) @(negedge clk);
        chk("midrst_reads_seen", (rd_total - rb) >= 7, 1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_ctrl", {icap_csib, icap_rdwrb, busy, done, err, m_axis_tvalid, m_axis_tlast}, 7'b1000000);
        chk("midrst_icap_i", icap_i, 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        m_axis_tready = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_no_done", done_cnt - db, 0);
        chk("midrst_tvalid_low", m_axis_tvalid, 0);
        run_txn(tbl[0]);

        chk("rdwrb_change_while_selected", proto_err, 0);
        chk("axis_unstable_while_stalled", stab_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icap_readback.md
ICAP_READBACK -- requirements
Module: icap_readback

Interface
REQ-001 Parameter: ICAP_RD_LAT, default 3, cycles from a read-enabled ICAP cycle (icap_csib=0, icap_rdwrb=1) to valid data on icap_o.
REQ-002 Parameter: FIFO_DEPTH, default 8, readback word buffer depth (power of 2, >= ICAP_RD_LAT+1).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a readback.
REQ-006 frame_addr  input  32  FAR value, sampled on accepted start.
REQ-007 word_count  input  16  number of 32-bit words to read, sampled on accepted start.
REQ-008 busy  output  1  high from accepted start until done pulse.
REQ-009 done  output  1  one-cycle pulse when the transfer completes.
REQ-010 err  output  1  one-cycle pulse on a rejected start.
REQ-011 m_axis_tvalid / m_axis_tready  output / input  1 / 1  AXI-Stream master handshake.
REQ-012 m_axis_tdata  output  32  readback word.
REQ-013 m_axis_tkeep  output  4  constant 4'hF.
REQ-014 m_axis_tlast  output  1  high on the word_count-th word only.
REQ-015 icap_csib / icap_rdwrb  output / output  1 / 1  to ICAPE2 CSIB / RDWRB.
REQ-016 icap_i  output  32  to ICAPE2 I.
REQ-017 icap_o  input  32  from ICAPE2 O.

Function
REQ-018 States SHALL be IDLE, CMD, TO_RD, READ, TO_WR, DESYNC, FLUSH.
REQ-019 In IDLE, start with word_count!=0 SHALL be accepted: latch inputs, busy=1, go CMD next cycle.
REQ-020 start with word_count==0 SHALL pulse err next cycle, with no ICAP activity and busy staying 0.
REQ-021 start while busy SHALL be ignored (no err).
REQ-022 CMD SHALL drive icap_csib=0, icap_rdwrb=0 for exactly 8 consecutive cycles, icap_i in order: AA995566, 20000000, 30008001, 00000004, 30002001, frame_addr, 28006000, 48000000|word_count.
REQ-023 TO_RD SHALL be 1 cycle with icap_csib=1, icap_rdwrb switching to 1; RDWRB SHALL change only while icap_csib=1.
REQ-024 READ SHALL issue a read cycle (icap_csib=0) only if fifo_count + inflight < FIFO_DEPTH and issued < word_count; otherwise icap_csib=1.
REQ-025 inflight SHALL be a ICAP_RD_LAT-deep valid shift register; icap_o SHALL be written into the FIFO exactly ICAP_RD_LAT cycles after each issued read; the FIFO SHALL never overflow.
REQ-026 After word_count reads are issued and inflight is empty, go TO_WR: 1 cycle, icap_csib=1, icap_rdwrb back to 0.
REQ-027 DESYNC SHALL drive 4 write cycles: 30008001, 0000000D, 20000000, 20000000; then FLUSH.
REQ-028 FLUSH SHALL wait until the FIFO is empty and the tlast word is accepted, then pulse done for 1 cycle, clear busy, return to IDLE.
REQ-029 m_axis_tvalid SHALL equal FIFO non-empty; words pop on tvalid&tready; tdata/tlast SHALL be stable while tvalid&!tready.
REQ-030 FIFO push and pop in the same cycle SHALL leave count unchanged; full push+pop is legal.
REQ-031 A 16-bit popped-word counter SHALL assert tlast when it equals word_count-1; word_count=65535 SHALL be supported without wrap.
REQ-032 In IDLE: icap_csib=1, icap_rdwrb=0, icap_i=0.

Reset
REQ-033 resetn low SHALL immediately force IDLE, icap_csib=1, icap_rdwrb=0, icap_i=0, busy=0, done=0, err=0, m_axis_tvalid=0, m_axis_tlast=0, all counters/FIFO empty.
REQ-034 Reset mid-transfer SHALL discard buffered and in-flight data; no done pulse is emitted.
REQ-035 Deassertion SHALL be taken synchronously to clk; first start is accepted on the 1st cycle after resetn is sampled high.

Verification
REQ-036 start, frame_addr=00400000, word_count=4, tready=1 -> 8 CMD words as REQ-022 (6th=00400000, 8th=48000004), 4 reads, 4 beats with tlast on 4th, desync words, done once.
REQ-037 word_count=20, tready=0 for 50 cycles then 1 -> icap_csib low at most FIFO_DEPTH times before first pop; no data loss; 20 beats in order.
REQ-038 word_count=0 start -> err pulse 1 cycle later, icap_csib stays 1, busy stays 0.
REQ-039 start pulsed again during READ -> ignored; exactly word_count beats and one done.
REQ-040 resetn low during READ with FIFO half-full -> all outputs at reset values same cycle; new start afterwards completes normally.
REQ-041 Random tready toggling, word_count=300 -> icap_rdwrb never changes while icap_csib=0; tdata matches ICAP model sequence.
